// File: rtl/deserializer_mc.sv
// Multi-channel serial-to-parallel receiver. External sclk/sdata/latch are oversampled
// in the clk domain; all channels shift in lockstep and load into a valid/ready holding register.
module deserializer_mc_lane #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_ev,
  input  logic             load_ev,
  input  logic             d,
  output logic [WIDTH-1:0] par
);
  logic [WIDTH-1:0] sr, sr_next;

  // Load captures the post-shift value so a coincident final bit is included.
  always_comb begin
    sr_next = sr;
    if (shift_ev) begin
      if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], d};
      else           sr_next = {d, sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      par <= '0;
    end else begin
      sr <= sr_next;
      if (load_ev) par <= sr_next;
    end
  end
endmodule

module deserializer_mc #(
  parameter int WIDTH       = 8,
  parameter int N_CH        = 1,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk_in,
  input  logic [N_CH-1:0]      sdata_in,
  input  logic                 latch_in,
  input  logic                 clr_status,
  output logic [N_CH*WIDTH-1:0] par_data,
  output logic                 par_valid,
  input  logic                 par_ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CW    = $clog2(WIDTH + 2);
  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int AW    = $clog2(ARM_N + 1);

  logic [SYNC_STAGES-1:0]           sclk_sync, latch_sync;
  logic [SYNC_STAGES-1:0][N_CH-1:0] sdata_sync;
  logic                             prev_sclk, prev_latch;
  logic [AW-1:0]                    arm_cnt;
  logic                             armed;
  logic [CW-1:0]                    bit_cnt, cnt_shift, cnt_eff;
  logic                             shift_ev, load_ev;
  logic [N_CH-1:0]                  d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync  <= '0;
      latch_sync <= '0;
      sdata_sync <= '0;
      prev_sclk  <= 1'b0;
      prev_latch <= 1'b0;
      arm_cnt    <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_in};
      prev_sclk  <= sclk_sync[SYNC_STAGES-1];
      prev_latch <= latch_sync[SYNC_STAGES-1];
      if (!armed) arm_cnt <= arm_cnt + AW'(1);
    end
  end

  // Edges are masked until a line held high across reset release has settled in prev_*.
  assign armed    = (arm_cnt == AW'(ARM_N));
  assign shift_ev = armed & sclk_sync[SYNC_STAGES-1] & ~prev_sclk;
  assign load_ev  = armed & latch_sync[SYNC_STAGES-1] & ~prev_latch;
  assign d        = sdata_sync[SYNC_STAGES-1];

  assign cnt_shift = (bit_cnt == CW'(WIDTH + 1)) ? bit_cnt : bit_cnt + CW'(1);
  assign cnt_eff   = shift_ev ? cnt_shift : bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      par_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load_ev) begin
        bit_cnt   <= '0;
        frame_err <= (cnt_eff != CW'(WIDTH));
        par_valid <= 1'b1;
      end else begin
        bit_cnt <= cnt_eff;
        if (par_valid && par_ready) par_valid <= 1'b0;
      end
      // A new overrun in the same cycle as clr_status takes priority.
      if (load_ev && par_valid && !par_ready) overrun <= 1'b1;
      else if (clr_status)                    overrun <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    deserializer_mc_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .shift_ev (shift_ev),
      .load_ev  (load_ev),
      .d        (d[i]),
      .par      (par_data[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_deserializer_mc.sv
// Bench for deserializer_mc: MSB-first and LSB-first instances share the serial inputs
// and are compared against a bit-history reference model.
module tb_deserializer_mc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk_in = 1'b0, latch_in = 1'b0, clr_status = 1'b0, par_ready = 1'b0;
  logic [1:0]  sdata_in = 2'b00;
  logic [15:0] par_data_m, par_data_l;
  logic        par_valid_m, par_valid_l, frame_err_m, frame_err_l, overrun_m, overrun_l;

  int vecs = 0, errs = 0;

  // reference model: every bit received since reset, per channel
  bit          hist0[$], hist1[$];
  int          mcnt;
  logic [15:0] exp_m, exp_l;
  logic        exp_valid, exp_err, exp_ovr;

  always #5 clk = ~clk;

  deserializer_mc #(.WIDTH(8), .N_CH(2), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_m (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .sdata_in(sdata_in), .latch_in(latch_in),
    .clr_status(clr_status), .par_data(par_data_m), .par_valid(par_valid_m),
    .par_ready(par_ready), .frame_err(frame_err_m), .overrun(overrun_m));

  deserializer_mc #(.WIDTH(8), .N_CH(2), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_l (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .sdata_in(sdata_in), .latch_in(latch_in),
    .clr_status(clr_status), .par_data(par_data_l), .par_valid(par_valid_l),
    .par_ready(par_ready), .frame_err(frame_err_l), .overrun(overrun_l));

  // last 8 bits received (zeros before the first) arranged by bit order
  function automatic logic [7:0] frame(input int ch, input bit msb);
    logic [7:0] v;
    int n, idx;
    bit b;
    v = '0;
    n = ch ? hist1.size() : hist0.size();
    for (int k = 0; k < 8; k++) begin
      idx = n - 8 + k;
      b = 1'b0;
      if (idx >= 0) b = ch ? hist1[idx] : hist0[idx];
      if (msb) v[7-k] = b;
      else     v[k]   = b;
    end
    return v;
  endfunction

  task automatic model_reset();
    hist0.delete(); hist1.delete();
    mcnt = 0; exp_m = '0; exp_l = '0;
    exp_valid = 0; exp_err = 0; exp_ovr = 0;
  endtask

  task automatic model_bit(input logic [1:0] b);
    hist0.push_back(b[0]); hist1.push_back(b[1]);
    if (mcnt < 9) mcnt++;
  endtask

  // ready is assumed held from before the frame until after the check
  task automatic model_load();
    exp_m   = {frame(1, 1), frame(0, 1)};
    exp_l   = {frame(1, 0), frame(0, 0)};
    exp_err = (mcnt != 8);
    mcnt    = 0;
    if (par_ready) exp_valid = 0;
    else begin
      if (exp_valid) exp_ovr = 1;
      exp_valid = 1;
    end
  endtask

  task automatic send_bit(input logic [1:0] b);
    sdata_in = b;
    repeat (3) @(negedge clk);
    sclk_in = 1'b1;
    model_bit(b);
    repeat (3) @(negedge clk);
    sclk_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w, input int n, input bit msb);
    for (int k = 0; k < n; k++)
      if (msb) send_bit({w[8 + n - 1 - k], w[n - 1 - k]});
      else     send_bit({w[8 + k], w[k]});
  endtask

  task automatic do_latch();
    @(negedge clk);
    latch_in = 1'b1;
    model_load();
    repeat (3) @(negedge clk);
    latch_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    vecs++; if ({par_data_m, par_data_l} !== 32'h0) begin errs++; $display("FAIL rst_data got %h/%h want 0", par_data_m, par_data_l); end
    vecs++; if ({par_valid_m, frame_err_m, overrun_m, par_valid_l, frame_err_l, overrun_l} !== 6'b0) begin
      errs++; $display("FAIL rst_flags got %b%b%b want 000", par_valid_m, frame_err_m, overrun_m); end
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_msb();
    send_word(16'h3CA5, 8, 1'b1);
    do_latch();
    vecs++; if (par_data_m !== 16'h3CA5) begin errs++; $display("FAIL t1_data got %h want 3ca5", par_data_m); end
    vecs++; if (par_valid_m !== 1'b1 || frame_err_m !== 1'b0) begin errs++; $display("FAIL t1_flags got v=%b e=%b want v=1 e=0", par_valid_m, frame_err_m); end
    vecs++; if (par_data_l !== exp_l) begin errs++; $display("FAIL t1_lsb_model got %h want %h", par_data_l, exp_l); end
  endtask

  task automatic test_lsb();
    par_ready = 1'b1;
    send_word(16'h00A5, 8, 1'b0);
    do_latch();
    vecs++; if (par_data_l[7:0] !== 8'hA5) begin errs++; $display("FAIL t2_data got %h want a5", par_data_l[7:0]); end
    vecs++; if (frame_err_l !== 1'b0) begin errs++; $display("FAIL t2_err got %b want 0", frame_err_l); end
    vecs++; if (par_data_m !== exp_m) begin errs++; $display("FAIL t2_msb_model got %h want %h", par_data_m, exp_m); end
    par_ready = 1'b0;
  endtask

  task automatic test_overrun();
    send_word(16'h1111, 8, 1'b1); do_latch();
    send_word(16'h2222, 8, 1'b1); do_latch();
    vecs++; if (par_data_m !== 16'h2222) begin errs++; $display("FAIL t3_data got %h want 2222", par_data_m); end
    vecs++; if (overrun_m !== 1'b1 || overrun_l !== 1'b1) begin errs++; $display("FAIL t3_ovr got %b%b want 11", overrun_m, overrun_l); end
    @(negedge clk) clr_status = 1'b1;
    @(negedge clk) clr_status = 1'b0;
    exp_ovr = 0;
    vecs++; if (overrun_m !== 1'b0) begin errs++; $display("FAIL t3_clr got %b want 0", overrun_m); end
    vecs++; if (par_valid_m !== 1'b1) begin errs++; $display("FAIL t3_hold got %b want 1", par_valid_m); end
    @(negedge clk) par_ready = 1'b1;
    @(negedge clk) par_ready = 1'b0;
    exp_valid = 0;
    vecs++; if (par_valid_m !== 1'b0 || par_valid_l !== 1'b0) begin errs++; $display("FAIL t3_consume got %b%b want 00", par_valid_m, par_valid_l); end
    vecs++; if (par_data_m !== 16'h2222) begin errs++; $display("FAIL t3_datahold got %h want 2222", par_data_m); end
  endtask

  task automatic test_frame_len();
    par_ready = 1'b1;
    send_word(16'h0055, 7, 1'b1); do_latch();
    vecs++; if (frame_err_m !== 1'b1) begin errs++; $display("FAIL t4_short got %b want 1", frame_err_m); end
    send_bit(2'b01);
    send_word(16'h00A5, 8, 1'b1); do_latch();
    vecs++; if (par_data_m[7:0] !== 8'hA5) begin errs++; $display("FAIL t4_long_data got %h want a5", par_data_m[7:0]); end
    vecs++; if (frame_err_m !== 1'b1) begin errs++; $display("FAIL t4_long_err got %b want 1", frame_err_m); end
    send_word(16'h0F0F, 8, 1'b1); do_latch();
    vecs++; if (frame_err_m !== 1'b0 || frame_err_l !== 1'b0) begin errs++; $display("FAIL t4_ok_err got %b%b want 00", frame_err_m, frame_err_l); end
    vecs++; if (par_data_l !== exp_l) begin errs++; $display("FAIL t4_lsb_model got %h want %h", par_data_l, exp_l); end
  endtask

  task automatic test_simultaneous();
    send_word(16'h6C6C, 7, 1'b1);
    sdata_in = 2'b11;
    repeat (3) @(negedge clk);
    sclk_in = 1'b1; latch_in = 1'b1;
    model_bit(2'b11); model_load();
    repeat (3) @(negedge clk);
    sclk_in = 1'b0; latch_in = 1'b0;
    repeat (6) @(negedge clk);
    vecs++; if (par_data_m !== 16'hD9D9) begin errs++; $display("FAIL t5_data got %h want d9d9", par_data_m); end
    vecs++; if (frame_err_m !== 1'b0) begin errs++; $display("FAIL t5_err got %b want 0", frame_err_m); end
    send_word(16'h8181, 8, 1'b1); do_latch();
    vecs++; if (frame_err_m !== 1'b0 || par_data_m !== 16'h8181) begin errs++; $display("FAIL t5_next got e=%b d=%h want e=0 d=8181", frame_err_m, par_data_m); end
  endtask

  task automatic test_reset_mid();
    par_ready = 1'b0;
    send_word(16'h0F0F, 8, 1'b1); do_latch();
    send_word(16'hFFFF, 4, 1'b1);
    sdata_in = 2'b11;
    @(negedge clk);
    sclk_in = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    vecs++; if ({par_data_m, par_valid_m, frame_err_m, overrun_m} !== 19'h0) begin
      errs++; $display("FAIL t6_async got d=%h v=%b e=%b o=%b want 0", par_data_m, par_valid_m, frame_err_m, overrun_m); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    vecs++; if ({par_data_m, par_valid_m, frame_err_m, overrun_m} !== 19'h0) begin
      errs++; $display("FAIL t6_release got d=%h v=%b e=%b o=%b want 0", par_data_m, par_valid_m, frame_err_m, overrun_m); end
    sclk_in = 1'b0;
    repeat (4) @(negedge clk);
    send_word(16'h5A5A, 8, 1'b1); do_latch();
    vecs++; if (par_data_m !== 16'h5A5A || frame_err_m !== 1'b0 || par_valid_m !== 1'b1) begin
      errs++; $display("FAIL t6_frame got d=%h e=%b v=%b want 5a5a 0 1", par_data_m, frame_err_m, par_valid_m); end
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 24; f++) begin
      par_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk) clr_status = 1'b1;
        @(negedge clk) clr_status = 1'b0;
        exp_ovr = 0;
      end
      n = $urandom_range(6, 10);
      for (int k = 0; k < n; k++) send_bit(2'($urandom));
      do_latch();
      vecs++; if (par_data_m !== exp_m) begin errs++; $display("FAIL rnd_data_m f=%0d got %h want %h", f, par_data_m, exp_m); end
      vecs++; if (par_data_l !== exp_l) begin errs++; $display("FAIL rnd_data_l f=%0d got %h want %h", f, par_data_l, exp_l); end
      vecs++; if (frame_err_m !== exp_err || frame_err_l !== exp_err) begin errs++; $display("FAIL rnd_err f=%0d got %b%b want %b", f, frame_err_m, frame_err_l, exp_err); end
      vecs++; if (par_valid_m !== exp_valid || par_valid_l !== exp_valid) begin errs++; $display("FAIL rnd_valid f=%0d got %b%b want %b", f, par_valid_m, par_valid_l, exp_valid); end
      vecs++; if (overrun_m !== exp_ovr || overrun_l !== exp_ovr) begin errs++; $display("FAIL rnd_ovr f=%0d got %b%b want %b", f, overrun_m, overrun_l, exp_ovr); end
    end
    par_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_msb();
    test_lsb();
    test_overrun();
    test_frame_len();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
